// File: rtl/transfer_reg_fifo_pkg.sv
// Shared definitions for the transfer register FIFO: default geometry, width helpers
// and the one-hot select check used when TRANSFER_SEL_CHECK_EN is defined.
package transfer_reg_fifo_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int NUM_SRC_DEF = 4;
    localparam int DEPTH_DEF   = 2;

    localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Select vectors are zero-extended to 32 bits, so NUM_SRC is limited to 32.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/transfer_reg_fifo_if.sv
// Load/drain bus of the transfer register FIFO; sel_err exists only with TRANSFER_SEL_CHECK_EN.
interface transfer_reg_fifo_if
    import transfer_reg_fifo_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DEPTH   = DEPTH_DEF
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_sel;
    logic                     load_valid;
    logic                     load_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W-1:0]         count;
`ifdef TRANSFER_SEL_CHECK_EN
    logic                     sel_err;

    modport master (
        output src_data, src_sel, load_valid, out_ready,
        input  load_ready, out_data, out_valid, count, sel_err
    );
    modport slave (
        input  src_data, src_sel, load_valid, out_ready,
        output load_ready, out_data, out_valid, count, sel_err
    );
`else
    modport master (
        output src_data, src_sel, load_valid, out_ready,
        input  load_ready, out_data, out_valid, count
    );
    modport slave (
        input  src_data, src_sel, load_valid, out_ready,
        output load_ready, out_data, out_valid, count
    );
`endif

endinterface

// File: rtl/transfer_or_nbit.sv
// AND-OR transfer logic: each selected source bus is gated onto the internal bus and ORed.
module transfer_or_nbit #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_sel,
    output logic [WIDTH-1:0]         xfer_word
);

    always_comb begin
        xfer_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            xfer_word = xfer_word | ({WIDTH{src_sel[i]}} & src_data[i*WIDTH +: WIDTH]);
        end
    end

endmodule

// File: rtl/transfer_reg_fifo.sv
// Multi-source transfer register feeding a DEPTH-entry FIFO with a registered head word.
// Optional macro TRANSFER_SEL_CHECK_EN drops loads whose select is not one-hot and flags sel_err.
module transfer_reg_fifo
    import transfer_reg_fifo_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    transfer_reg_fifo_if.slave  bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] xfer_word;
    logic             load_ready;
    logic             push;
    logic             pop;
    logic             store;

    transfer_or_nbit #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_or (
        .src_data  (bus.src_data),
        .src_sel   (bus.src_sel),
        .xfer_word (xfer_word)
    );

    assign load_ready  = (count_q < CNT_W'(DEPTH));
    assign push        = bus.load_valid && load_ready;
    assign pop         = (count_q != '0) && bus.out_ready;
    assign rd_ptr_next = rd_ptr_q + PTR_W'(1);

`ifdef TRANSFER_SEL_CHECK_EN
    logic sel_ok;
    logic sel_err_q, sel_err_d;

    assign sel_ok    = is_onehot(32'(bus.src_sel));
    assign store     = push && sel_ok;
    assign sel_err_d = push && !sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.sel_err = sel_err_q;
`else
    assign store = push;
`endif

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        out_data_d = out_data_q;
        count_d    = count_q + CNT_W'(store) - CNT_W'(pop);

        if (store) begin
            mem_d[wr_ptr_q] = xfer_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_next;
        end

        // Head changes only when the buffer becomes non-empty with this word or the head pops.
        if (store && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
            out_data_d = xfer_word;
        end else if (pop && (count_q >= CNT_W'(2))) begin
            out_data_d = mem_q[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_data   = out_data_q;
    assign bus.count      = count_q;

endmodule

// File: tb/tb_transfer_reg_fifo.sv
// Directed bench for transfer_reg_fifo: DEPTH=2 instance for most scenarios, DEPTH=4 for pointer wrap.
module tb_transfer_reg_fifo;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    transfer_reg_fifo_if #(.WIDTH(8), .NUM_SRC(4), .DEPTH(2)) bus_a ();
    transfer_reg_fifo_if #(.WIDTH(8), .NUM_SRC(4), .DEPTH(4)) bus_b ();

    transfer_reg_fifo #(.WIDTH(8), .NUM_SRC(4), .DEPTH(2)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    transfer_reg_fifo #(.WIDTH(8), .NUM_SRC(4), .DEPTH(4)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.src_data   = '0;
        bus_a.src_sel    = '0;
        bus_a.load_valid = 1'b0;
        bus_a.out_ready  = 1'b0;
        bus_b.src_data   = '0;
        bus_b.src_sel    = '0;
        bus_b.load_valid = 1'b0;
        bus_b.out_ready  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
        checks++; if (bus_a.count !== 2'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", bus_a.count); end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b required=0", bus_a.out_valid); end
        checks++; if (bus_a.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data actual=%h required=00", bus_a.out_data); end
        checks++; if (bus_a.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready actual=%b required=1", bus_a.load_ready); end
        checks++; if (bus_b.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready_b actual=%b required=1", bus_b.load_ready); end
`ifdef TRANSFER_SEL_CHECK_EN
        checks++; if (bus_a.sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err actual=%b required=0", bus_a.sel_err); end
`endif
    endtask

    task automatic test_single_push();
        bus_a.src_data   = 32'h11_A5_33_44;
        bus_a.src_sel    = 4'b0100;
        bus_a.load_valid = 1'b1;
        bus_a.out_ready  = 1'b0;
        step();
        bus_a.load_valid = 1'b0;
        checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL push1_valid actual=%b required=1", bus_a.out_valid); end
        checks++; if (bus_a.out_data !== 8'hA5) begin errors++; $display("FAIL push1_data actual=%h required=a5", bus_a.out_data); end
        checks++; if (bus_a.count !== 2'd1) begin errors++; $display("FAIL push1_count actual=%0d required=1", bus_a.count); end
        bus_a.src_data = 32'hFF_FF_FF_FF;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'hA5) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d actual=%b/%h required=1/a5", i, bus_a.out_valid, bus_a.out_data);
            end
        end
        bus_a.out_ready = 1'b1;
        step();
        bus_a.out_ready = 1'b0;
        checks++; if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 8'hA5) begin errors++; $display("FAIL push1_drain actual=%b/%h required=0/a5", bus_a.out_valid, bus_a.out_data); end
    endtask

    task automatic test_full();
        bus_a.src_sel    = 4'b0001;
        bus_a.load_valid = 1'b1;
        bus_a.src_data   = 32'h00_00_00_01;
        step();
        bus_a.src_data   = 32'h00_00_00_02;
        step();
        checks++; if (bus_a.count !== 2'd2) begin errors++; $display("FAIL full_count actual=%0d required=2", bus_a.count); end
        checks++; if (bus_a.load_ready !== 1'b0) begin errors++; $display("FAIL full_load_ready actual=%b required=0", bus_a.load_ready); end
        bus_a.src_data = 32'h00_00_00_03;
        step();
        checks++; if (bus_a.count !== 2'd2 || bus_a.out_data !== 8'h01) begin errors++; $display("FAIL full_reject actual=%0d/%h required=2/01", bus_a.count, bus_a.out_data); end
        // load_valid stays high while popping from full: still no accept
        bus_a.out_ready = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
        checks++; if (bus_a.count !== 2'd1 || bus_a.out_data !== 8'h02) begin errors++; $display("FAIL full_pop1 actual=%0d/%h required=1/02", bus_a.count, bus_a.out_data); end
        step();
        bus_a.out_ready = 1'b0;
        checks++; if (bus_a.count !== 2'd0 || bus_a.out_valid !== 1'b0 || bus_a.out_data !== 8'h02) begin
            errors++; $display("FAIL full_empty actual=%0d/%b/%h required=0/0/02", bus_a.count, bus_a.out_valid, bus_a.out_data);
        end
    endtask

    task automatic test_back_to_back();
        bus_a.src_sel    = 4'b1000;
        bus_a.src_data   = 32'h10_00_00_00;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.src_data   = 32'h20_00_00_00;
        bus_a.out_ready  = 1'b1;
        step();
        checks++; if (bus_a.count !== 2'd1 || bus_a.out_data !== 8'h20) begin errors++; $display("FAIL simul_pushpop actual=%0d/%h required=1/20", bus_a.count, bus_a.out_data); end
        for (int i = 0; i < 100; i++) begin
            logic [7:0] w;
            w = 8'(i + 8'h40);
            bus_a.src_data = {w, 24'h0};
            step();
            checks++;
            if (bus_a.out_data !== w || bus_a.count !== 2'd1) begin
                errors++;
                $display("FAIL stream word=%0d actual=%h/%0d required=%h/1", i, bus_a.out_data, bus_a.count, w);
            end
        end
        bus_a.load_valid = 1'b0;
        step();
        bus_a.out_ready = 1'b0;
        checks++; if (bus_a.count !== 2'd0 || bus_a.out_data !== 8'hA3) begin errors++; $display("FAIL stream_drain actual=%0d/%h required=0/a3", bus_a.count, bus_a.out_data); end
    endtask

    task automatic test_async_reset();
        bus_a.src_sel    = 4'b0010;
        bus_a.load_valid = 1'b1;
        bus_a.src_data   = 32'h00_00_77_00;
        step();
        bus_a.src_data   = 32'h00_00_88_00;
        step();
        bus_a.load_valid = 1'b0;
        checks++; if (bus_a.count !== 2'd2) begin errors++; $display("FAIL arst_pre_count actual=%0d required=2", bus_a.count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.count !== 2'd0 || bus_a.out_valid !== 1'b0 || bus_a.out_data !== 8'h00 || bus_a.load_ready !== 1'b1) begin
            errors++; $display("FAIL arst_clear actual=%0d/%b/%h/%b required=0/0/00/1", bus_a.count, bus_a.out_valid, bus_a.out_data, bus_a.load_ready);
        end
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sel_check();
        // leave a nonzero head value behind so a stored zero is observable
        bus_a.src_sel    = 4'b0001;
        bus_a.src_data   = 32'h00_00_00_5A;
        bus_a.load_valid = 1'b1;
        bus_a.out_ready  = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
        step();
        bus_a.out_ready  = 1'b0;
        bus_a.src_data   = 32'h00_00_F0_0F;
        bus_a.src_sel    = 4'b0011;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
`ifdef TRANSFER_SEL_CHECK_EN
        checks++; if (bus_a.count !== 2'd0 || bus_a.out_data !== 8'h5A) begin errors++; $display("FAIL multisel_drop actual=%0d/%h required=0/5a", bus_a.count, bus_a.out_data); end
        checks++; if (bus_a.sel_err !== 1'b1) begin errors++; $display("FAIL multisel_err actual=%b required=1", bus_a.sel_err); end
        step();
        checks++; if (bus_a.sel_err !== 1'b0) begin errors++; $display("FAIL multisel_err_clear actual=%b required=0", bus_a.sel_err); end
`else
        checks++; if (bus_a.count !== 2'd1 || bus_a.out_data !== 8'hFF) begin errors++; $display("FAIL multisel_or actual=%0d/%h required=1/ff", bus_a.count, bus_a.out_data); end
        bus_a.out_ready = 1'b1;
        step();
        bus_a.out_ready = 1'b0;
`endif
        bus_a.src_sel    = 4'b0000;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
`ifdef TRANSFER_SEL_CHECK_EN
        checks++; if (bus_a.count !== 2'd0 || bus_a.sel_err !== 1'b1) begin errors++; $display("FAIL zerosel_drop actual=%0d/%b required=0/1", bus_a.count, bus_a.sel_err); end
`else
        checks++; if (bus_a.count !== 2'd1 || bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h00) begin
            errors++; $display("FAIL zerosel_store actual=%0d/%b/%h required=1/1/00", bus_a.count, bus_a.out_valid, bus_a.out_data);
        end
        bus_a.out_ready = 1'b1;
        step();
        bus_a.out_ready = 1'b0;
`endif
    endtask

    task automatic test_wrap();
        bus_b.src_sel    = 4'b0001;
        bus_b.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_b.src_data = {24'h0, 8'(8'h30 + i)};
            step();
        end
        bus_b.load_valid = 1'b0;
        checks++; if (bus_b.count !== 3'd4 || bus_b.load_ready !== 1'b0) begin errors++; $display("FAIL wrap_full actual=%0d/%b required=4/0", bus_b.count, bus_b.load_ready); end
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus_b.out_data !== 8'(8'h30 + i)) begin errors++; $display("FAIL wrap_pop idx=%0d actual=%h required=%h", i, bus_b.out_data, 8'(8'h30 + i)); end
            step();
        end
        bus_b.out_ready  = 1'b0;
        bus_b.load_valid = 1'b1;
        for (int i = 4; i < 6; i++) begin
            bus_b.src_data = {24'h0, 8'(8'h30 + i)};
            step();
        end
        bus_b.load_valid = 1'b0;
        checks++; if (bus_b.count !== 3'd4) begin errors++; $display("FAIL wrap_refill actual=%0d required=4", bus_b.count); end
        bus_b.out_ready = 1'b1;
        for (int i = 2; i < 6; i++) begin
            checks++; if (bus_b.out_data !== 8'(8'h30 + i)) begin errors++; $display("FAIL wrap_pop idx=%0d actual=%h required=%h", i, bus_b.out_data, 8'(8'h30 + i)); end
            step();
        end
        bus_b.out_ready  = 1'b0;
        bus_b.load_valid = 1'b1;
        for (int i = 6; i < 10; i++) begin
            bus_b.src_data = {24'h0, 8'(8'h30 + i)};
            step();
        end
        bus_b.load_valid = 1'b0;
        bus_b.out_ready  = 1'b1;
        for (int i = 6; i < 10; i++) begin
            checks++; if (bus_b.out_data !== 8'(8'h30 + i)) begin errors++; $display("FAIL wrap_pop idx=%0d actual=%h required=%h", i, bus_b.out_data, 8'(8'h30 + i)); end
            step();
        end
        bus_b.out_ready = 1'b0;
        checks++; if (bus_b.count !== 3'd0 || bus_b.out_data !== 8'h39) begin errors++; $display("FAIL wrap_empty actual=%0d/%h required=0/39", bus_b.count, bus_b.out_data); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        idle_inputs();
        test_reset();
        test_single_push();
        test_full();
        test_back_to_back();
        test_async_reset();
        test_sel_check();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transfer_reg_fifo.md
# transfer_reg_fifo

Parametrised multi-source transfer register: each accepted load selects one of NUM_SRC WIDTH-bit source buses with a one-hot select and gates it onto an internal bus with AND-OR transfer logic. The result is queued in a DEPTH-entry buffer and presented on a registered output with valid/ready handshake. It is the datapath load point between the ALU/register-file/memory sources and the next stage that may stall.

## Interface
- WIDTH, 8, data width in bits (≥1)
- NUM_SRC, 4, number of source buses (≥2)
- DEPTH, 2, buffer entries (power of two, ≥2)

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- src_data  input  NUM_SRC*WIDTH  source buses, source i at bits [i*WIDTH +: WIDTH]
- src_sel  input  NUM_SRC  one-hot source select
- load_valid  input  1  load request
- load_ready  output  1  buffer can accept a load
- out_data  output  WIDTH  head word (holding register)
- out_valid  output  1  out_data holds an undelivered word
- out_ready  input  1  consumer accepts head
- count  output  $clog2(DEPTH+1)  words currently held, including head
- sel_err  output  1  illegal select flag (present only with TRANSFER_SEL_CHECK_EN)

## Operation
- Transfer word: bitwise OR over i of ({WIDTH{src_sel[i]}} & src_data[i]); all-zero select yields 0.
- Push: load_valid && load_ready. Pop: out_valid && out_ready.
- load_ready = (count < DEPTH); purely from state, never from out_ready. When full, no load is accepted, even with a simultaneous pop.
- FIFO order is strict. The head is copied into out_data.
- out_data changes only when the head changes:
  - push into empty: load out_data with the pushed word.
  - pop with count ≥ 2: load out_data with the next word.
  - Otherwise out_data holds its value.
- After the last word pops, out_valid=0 and out_data keeps the last delivered word (hold semantics).
- Simultaneous push and pop with 1 ≤ count < DEPTH: count is unchanged.
  - count == 1: out_data takes the pushed word.
  - count ≥ 2: out_data takes the next stored word.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Reset values: count=0, out_valid=0, out_data=0, load_ready=1, sel_err=0, pointers=0.
- Asserting rst_n low mid-operation discards all contents immediately.

## Timing
- Load-to-output latency: 1 cycle. A word pushed at edge N into an empty buffer has out_valid=1 and out_data valid after edge N.
- Throughput: 1 word/cycle while 0 < count < DEPTH.
- out_data and out_valid are stable while out_valid && !out_ready.
- All outputs are registered or derived from registers only. There is no combinational input-to-output path.

## Configuration
- TRANSFER_SEL_CHECK_EN defined:
  - A push whose src_sel is not exactly one-hot (zero or multiple bits set) is consumed (handshake completes) but not stored; count is unchanged.
  - sel_err is 1 for exactly the cycle after that edge.
- TRANSFER_SEL_CHECK_EN undefined:
  - The sel_err port is absent.
  - Any src_sel value is stored as the OR of all selected sources (zero select stores 0).

## Structure
- Shared package: localparams for the count and pointer widths ($clog2(DEPTH+1), $clog2(DEPTH)), plus the one-hot check function.
- One sub-module, transfer_or_nbit: combinational NUM_SRC×WIDTH AND-OR select producing the transfer word.
- Buffer storage, pointers, count and the holding register stay in the top module.

## Test plan
- WIDTH=8, NUM_SRC=4: reset, then push src_sel=4'b0100 with src2=8'hA5 and out_ready=0 -> after 1 edge: out_valid=1, out_data=8'hA5, count=1; held stable for 5 stalled cycles.
- Push 8'h01, 8'h02 with out_ready=0 -> count=2, load_ready=0. A third load_valid is not accepted. Then out_ready=1 -> 8'h01, then 8'h02 delivered, then out_valid=0, out_data stays 8'h02.
- count=1 (head 8'h10); simultaneous push 8'h20 and pop -> count=1, out_data=8'h20 next cycle. Continuous push/pop of 100 words -> order preserved, no loss.
- Drop rst_n asynchronously with count=2 -> count=0, out_valid=0, out_data=0, load_ready=1 before the next clock edge.
- Macro defined: push src_sel=4'b0011 -> not stored, count unchanged, sel_err=1 for one cycle. Macro undefined: the same push stores src0|src1.
- src_sel=0 push (macro undefined) -> stores 8'h00. Wrap test with DEPTH=4: push/pop 10 words -> correct order across pointer wrap.
